// File: rtl/ysyx_23060236_btb_2way.sv
// Two-way set-associative branch target buffer with 2-bit direction counters.
// Two independent zero-latency lookup ports (fetch, execute) and one update port.
module ysyx_23060236_btb_2way #(
  parameter int ADDR_LEN   = 32,
  parameter int SET_LEN    = 4,
  parameter int OFFSET_LEN = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic [ADDR_LEN-1:0] ifu_pc,
  output logic [ADDR_LEN-1:0] ifu_npc,
  output logic                ifu_hit,
  input  logic [ADDR_LEN-1:0] exu_pc,
  output logic [ADDR_LEN-1:0] exu_npc,
  input  logic                upd_valid,
  input  logic [ADDR_LEN-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [ADDR_LEN-1:0] upd_target
);

  localparam int SETS  = 1 << SET_LEN;
  localparam int TAG_W = ADDR_LEN - OFFSET_LEN - SET_LEN;

  // upd_valid is a single-cycle strobe with no ready: every asserted cycle is
  // consumed, unless reset or flush is asserted in the same cycle.

  logic [1:0]          valid_q  [SETS];
  logic [TAG_W-1:0]    tag_q    [SETS][2];
  logic [ADDR_LEN-1:0] target_q [SETS][2];
  logic [1:0]          cnt_q    [SETS][2];
  logic [SETS-1:0]     lru_q;

  // Returns {hit, way}; way is only meaningful when hit is set.
  function automatic logic [1:0] lookup(input logic [ADDR_LEN-1:0] pc);
    logic [SET_LEN-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic               m0, m1;
    idx = pc[OFFSET_LEN +: SET_LEN];
    tg  = pc[ADDR_LEN-1 -: TAG_W];
    m0  = valid_q[idx][0] && (tag_q[idx][0] == tg);
    m1  = valid_q[idx][1] && (tag_q[idx][1] == tg);
    return {m0 | m1, ~m0};
  endfunction

  function automatic logic [ADDR_LEN-1:0] predict(input logic [ADDR_LEN-1:0] pc,
                                                  input logic [1:0] lk);
    logic [SET_LEN-1:0] idx;
    idx = pc[OFFSET_LEN +: SET_LEN];
    if (lk[1] && cnt_q[idx][lk[0]][1]) return target_q[idx][lk[0]];
    return pc + ADDR_LEN'(4);
  endfunction

  logic [1:0]         ifu_lk, exu_lk, upd_lk;
  logic [SET_LEN-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_way, upd_victim;
  logic [1:0]         upd_cnt;
  logic               unused_upd_low;

  always_comb begin
    ifu_lk     = lookup(ifu_pc);
    exu_lk     = lookup(exu_pc);
    upd_lk     = lookup(upd_pc);
    ifu_hit    = ifu_lk[1];
    ifu_npc    = predict(ifu_pc, ifu_lk);
    exu_npc    = predict(exu_pc, exu_lk);
    upd_idx    = upd_pc[OFFSET_LEN +: SET_LEN];
    upd_tag    = upd_pc[ADDR_LEN-1 -: TAG_W];
    upd_way    = upd_lk[0];
    upd_cnt    = cnt_q[upd_idx][upd_way];
    // Fill invalid ways first so a set never holds two copies of a tag.
    if (!valid_q[upd_idx][0])      upd_victim = 1'b0;
    else if (!valid_q[upd_idx][1]) upd_victim = 1'b1;
    else                           upd_victim = lru_q[upd_idx];
  end

  assign unused_upd_low = ^upd_pc[OFFSET_LEN-1:0];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
      lru_q <= '0;
    end else if (upd_valid) begin
      if (upd_lk[1]) begin
        if (upd_taken) begin
          if (upd_cnt != 2'd3) cnt_q[upd_idx][upd_way] <= upd_cnt + 2'd1;
          target_q[upd_idx][upd_way] <= upd_target;
        end else if (upd_cnt != 2'd0) begin
          cnt_q[upd_idx][upd_way] <= upd_cnt - 2'd1;
        end
        lru_q[upd_idx] <= ~upd_way;
      end else if (upd_taken) begin
        valid_q[upd_idx][upd_victim]  <= 1'b1;
        tag_q[upd_idx][upd_victim]    <= upd_tag;
        target_q[upd_idx][upd_victim] <= upd_target;
        cnt_q[upd_idx][upd_victim]    <= 2'd2;
        lru_q[upd_idx]                <= ~upd_victim;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_btb_2way.sv
// Directed bench for the 2-way BTB: the driver queues expected lookup results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ysyx_23060236_btb_2way;

  localparam int W = 65;  // {ifu_hit, ifu_npc, exu_npc}

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] ifu_pc = '0, ifu_npc;
  logic        ifu_hit;
  logic [31:0] exu_pc = '0, exu_npc;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  localparam logic [31:0] A  = 32'h8000_0010;
  localparam logic [31:0] B  = 32'h8000_0050;
  localparam logic [31:0] C  = 32'h8000_0090;
  localparam logic [31:0] T  = 32'h8000_0100;
  localparam logic [31:0] T2 = 32'h8000_0200;
  localparam logic [31:0] TB = 32'h8000_0500;
  localparam logic [31:0] TC = 32'h8000_0900;

  ysyx_23060236_btb_2way dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .ifu_pc     (ifu_pc),
    .ifu_npc    (ifu_npc),
    .ifu_hit    (ifu_hit),
    .exu_pc     (exu_pc),
    .exu_npc    (exu_npc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  always #5 clock = ~clock;

  task automatic step(input logic rs, input logic fl, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                      input logic [31:0] ipc, input logic [31:0] epc,
                      input logic chk, input logic eh,
                      input logic [31:0] e_inpc, input logic [31:0] e_enpc,
                      input string nm);
    @(posedge clock);
    #1;
    reset = rs; flush = fl; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; ifu_pc = ipc; exu_pc = epc;
    if (chk) begin
      exp_q.push_back({eh, e_inpc, e_enpc});
      name_q.push_back(nm);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    step(1'b0, 1'b0, 1'b1, pc, taken, tgt, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "");
  endtask

  task automatic look(input logic [31:0] ipc, input logic [31:0] epc, input logic eh,
                      input logic [31:0] e_inpc, input logic [31:0] e_enpc, input string nm);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ipc, epc, 1'b1, eh, e_inpc, e_enpc, nm);
  endtask

  // Monitor: outputs are combinational, so they are settled by the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (ifu_hit !== e[64]) begin
        errors++;
        $display("FAIL %s ifu_hit: got %b expected %b", nm, ifu_hit, e[64]);
      end
      checks++;
      if (ifu_npc !== e[63:32]) begin
        errors++;
        $display("FAIL %s ifu_npc: got %h expected %h", nm, ifu_npc, e[63:32]);
      end
      checks++;
      if (exu_npc !== e[31:0]) begin
        errors++;
        $display("FAIL %s exu_npc: got %h expected %h", nm, exu_npc, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // Reset held together with a taken update: nothing may be allocated.
    step(1'b1, 1'b0, 1'b1, A, 1'b1, T, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "");
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "");
    look(32'h8000_0000, A, 1'b0, 32'h8000_0004, 32'h8000_0014, "reset_state");
    look(32'hFFFF_FFFC, 32'h7FFF_FFFC, 1'b0, 32'h0000_0000, 32'h8000_0000, "pc_wrap");

    // Allocation; the update cycle itself still sees the old state.
    step(1'b0, 1'b0, 1'b1, A, 1'b1, T, A, A, 1'b1, 1'b0, 32'h8000_0014, 32'h8000_0014, "upd_cycle");
    look(A, 32'h8000_0030, 1'b1, T, 32'h8000_0034, "alloc_hit");

    // Counter walk: 2 -> 1 -> 2 -> 3 (new target) -> 3 -> 3 -> 2.
    step(1'b0, 1'b0, 1'b1, A, 1'b0, 32'h0, A, A, 1'b1, 1'b1, T, T, "nt_cycle");
    step(1'b0, 1'b0, 1'b1, A, 1'b1, T, A, A, 1'b1, 1'b1, 32'h8000_0014, 32'h8000_0014, "cnt1");
    step(1'b0, 1'b0, 1'b1, A, 1'b1, T2, A, A, 1'b1, 1'b1, T, T, "cnt2");
    upd(A, 1'b1, T2);
    upd(A, 1'b1, T2);
    upd(A, 1'b0, 32'h0);
    look(A, A, 1'b1, T2, T2, "sat_then_nt");

    // Cold not-taken: no allocation.
    upd(32'h8000_0020, 1'b0, 32'h0);
    look(32'h8000_0020, A, 1'b0, 32'h8000_0024, T2, "cold_nt");

    // Flush discards a same-cycle allocation.
    step(1'b0, 1'b1, 1'b1, 32'h8000_0030, 1'b1, 32'h8000_0300, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 32'h0, "");
    look(32'h8000_0030, A, 1'b0, 32'h8000_0034, 32'h8000_0014, "flush");

    // Eviction in set 4: LRU victim is the oldest way.
    upd(A, 1'b1, T);
    upd(B, 1'b1, TB);
    upd(C, 1'b1, TC);
    look(A, B, 1'b0, 32'h8000_0014, TB, "evict_a");
    look(C, B, 1'b1, TC, TB, "evict_a_keep");

    // Touching A before the third allocation makes B the victim.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "");
    upd(A, 1'b1, T);
    upd(B, 1'b1, TB);
    upd(A, 1'b1, T);
    upd(C, 1'b1, TC);
    look(A, B, 1'b1, T, 32'h8000_0054, "evict_b");
    look(C, A, 1'b1, TC, T, "evict_b_keep");

    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "");
    @(posedge clock);
    @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
